// File: rtl/sram_arbiter.sv
// SRAM arbiter: AVR read/write sequencer sharing one async SRAM with a pass-through SNES port. Optional macro: SRAM_ARB_AUTOINC_EN.
// Latency: read data valid (avr_rvalid) in the 3rd cycle after acceptance; a write occupies 3 cycles after acceptance.
// Backpressure: avr_busy high outside IDLE or while snes_mode=1; requests seen while busy are dropped, never queued.
module sram_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        snes_mode,
    input  logic [20:0] avr_addr,
    input  logic        avr_addr_load,
    input  logic [7:0]  avr_wdata,
    input  logic        avr_rd_req,
    input  logic        avr_wr_req,
    output logic        avr_busy,
    output logic [7:0]  avr_rdata,
    output logic        avr_rvalid,
    input  logic [20:0] snes_addr,
    input  logic        snes_rd_n,
    output logic [7:0]  snes_data,
    output logic [20:0] sram_addr,
    input  logic [7:0]  sram_din,
    output logic [7:0]  sram_dout,
    output logic        sram_drive,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        WR_A = 3'd3,
        WR_B = 3'd4,
        WR_C = 3'd5,
        SNES = 3'd6
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [20:0] addr_q;
    logic [7:0]  wdata_q;
    logic [20:0] access_addr;
    logic        accept;
    logic        access_done;

    assign accept      = (state == IDLE) && !snes_mode && (avr_rd_req || avr_wr_req);
    assign access_done = (state == RD_B) || (state == WR_C);

`ifdef SRAM_ARB_AUTOINC_EN
    logic [20:0] addr_cnt;

    // A load coinciding with acceptance addresses the freshly loaded value.
    assign access_addr = avr_addr_load ? avr_addr : addr_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_cnt <= 21'd0;
        end else if (avr_addr_load) begin
            addr_cnt <= avr_addr;
        end else if (access_done) begin
            addr_cnt <= addr_cnt + 21'd1;
        end
    end
`else
    logic unused_addr_load;

    assign access_addr      = avr_addr;
    assign unused_addr_load = avr_addr_load;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= 21'd0;
            wdata_q    <= 8'd0;
            avr_rdata  <= 8'd0;
            avr_rvalid <= 1'b0;
        end else begin
            state      <= state_nxt;
            avr_rvalid <= (state == RD_B);
            if (state == RD_B) begin
                avr_rdata <= sram_din;
            end
            if (accept) begin
                addr_q <= access_addr;
                if (avr_wr_req) begin
                    wdata_q <= avr_wdata;
                end
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_drive = 1'b0;
        case (state)
            IDLE: begin
                // Write outranks read when both are requested together.
                if (snes_mode) begin
                    state_nxt = SNES;
                end else if (avr_wr_req) begin
                    state_nxt = WR_A;
                end else if (avr_rd_req) begin
                    state_nxt = RD_A;
                end
            end
            RD_A: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
                state_nxt = RD_B;
            end
            RD_B: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
                state_nxt = IDLE;
            end
            WR_A: begin
                sram_ce_n  = 1'b0;
                sram_drive = 1'b1;
                state_nxt  = WR_B;
            end
            WR_B: begin
                sram_ce_n  = 1'b0;
                sram_we_n  = 1'b0;
                sram_drive = 1'b1;
                state_nxt  = WR_C;
            end
            WR_C: begin
                sram_ce_n  = 1'b0;
                sram_drive = 1'b1;
                state_nxt  = IDLE;
            end
            SNES: begin
                sram_ce_n = 1'b0;
                sram_oe_n = snes_rd_n;
                if (!snes_mode) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign avr_busy  = (state != IDLE) || snes_mode;
    assign sram_addr = (state == SNES) ? snes_addr : addr_q;
    assign sram_dout = wdata_q;
    assign snes_data = (state == SNES) ? sram_din : 8'hFF;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural SRAM and a read-data scoreboard.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        snes_mode;
    logic [20:0] avr_addr;
    logic        avr_addr_load;
    logic [7:0]  avr_wdata;
    logic        avr_rd_req;
    logic        avr_wr_req;
    logic        avr_busy;
    logic [7:0]  avr_rdata;
    logic        avr_rvalid;
    logic [20:0] snes_addr;
    logic        snes_rd_n;
    logic [7:0]  snes_data;
    logic [20:0] sram_addr;
    logic [7:0]  sram_din = 8'h00;
    logic [7:0]  sram_dout;
    logic        sram_drive;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;

    int tests = 0;
    int fails = 0;

    logic [7:0]  mem [int unsigned];
    logic [20:0] wr_log [$];
    logic [7:0]  exp_q [$];
    int          we_cnt = 0;
    int          drv_cnt = 0;
    int          oe_cnt = 0;
    int          rv_cnt = 0;
    logic        force_din = 1'b0;
    logic [7:0]  din_val = 8'h00;

    sram_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .snes_mode    (snes_mode),
        .avr_addr     (avr_addr),
        .avr_addr_load(avr_addr_load),
        .avr_wdata    (avr_wdata),
        .avr_rd_req   (avr_rd_req),
        .avr_wr_req   (avr_wr_req),
        .avr_busy     (avr_busy),
        .avr_rdata    (avr_rdata),
        .avr_rvalid   (avr_rvalid),
        .snes_addr    (snes_addr),
        .snes_rd_n    (snes_rd_n),
        .snes_data    (snes_data),
        .sram_addr    (sram_addr),
        .sram_din     (sram_din),
        .sram_dout    (sram_dout),
        .sram_drive   (sram_drive),
        .sram_ce_n    (sram_ce_n),
        .sram_oe_n    (sram_oe_n),
        .sram_we_n    (sram_we_n)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rd_mem(input logic [20:0] a);
        int unsigned k;
        k = a;
        return mem.exists(k) ? mem[k] : 8'h00;
    endfunction

    // SRAM model and activity counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            mem[sram_addr] = sram_dout;
            wr_log.push_back(sram_addr);
        end
        if (!sram_we_n)  we_cnt++;
        if (sram_drive)  drv_cnt++;
        if (!sram_oe_n)  oe_cnt++;
        if (avr_rvalid)  rv_cnt++;
        sram_din = force_din ? din_val : rd_mem(sram_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; any rvalid pulse is matched against the scoreboard.
    task automatic tick();
        logic [7:0] e;
        @(posedge clk);
        #1;
        if (avr_rvalid) begin
            chk("rvalid_expected", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rdata_scoreboard", avr_rdata, e);
            end
        end
    endtask

    task automatic do_write(input logic [20:0] a, input logic [7:0] d);
        avr_addr   = a;
        avr_wdata  = d;
        avr_wr_req = 1'b1;
        tick();
        avr_wr_req = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic do_read(input logic [20:0] a, input logic [7:0] d);
        exp_q.push_back(d);
        avr_addr   = a;
        avr_rd_req = 1'b1;
        tick();
        avr_rd_req = 1'b0;
        tick();
        tick();
        chk("read_rvalid", avr_rvalid, 1);
        tick();
    endtask

    initial begin
        int w0, d0, o0, r0, l0;
        reset         = 1'b1;
        snes_mode     = 1'b0;
        avr_addr      = 21'd0;
        avr_addr_load = 1'b1;
        avr_wdata     = 8'd0;
        avr_rd_req    = 1'b0;
        avr_wr_req    = 1'b0;
        snes_addr     = 21'd0;
        snes_rd_n     = 1'b1;
        mem[32'h12345] = 8'hA5;
        tick();
        tick();
        chk("rst_ce_n", sram_ce_n, 1);
        chk("rst_oe_n", sram_oe_n, 1);
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_drive", sram_drive, 0);
        chk("rst_rdata", avr_rdata, 8'h00);
        chk("rst_rvalid", avr_rvalid, 0);
        chk("rst_addr", sram_addr, 21'd0);
        chk("rst_dout", sram_dout, 8'd0);
        chk("rst_snes_data", snes_data, 8'hFF);
        reset = 1'b0;
        tick();
        chk("idle_busy", avr_busy, 0);

        // Read with latency and strobe-count checks.
        o0 = oe_cnt; r0 = rv_cnt;
        exp_q.push_back(8'hA5);
        avr_addr   = 21'h012345;
        avr_rd_req = 1'b1;
        tick();
        avr_rd_req = 1'b0;
        chk("rd_a_oe_n", sram_oe_n, 0);
        chk("rd_a_we_n", sram_we_n, 1);
        chk("rd_a_drive", sram_drive, 0);
        chk("rd_addr", sram_addr, 21'h012345);
        chk("rd_busy", avr_busy, 1);
        tick();
        chk("rd_b_oe_n", sram_oe_n, 0);
        chk("rd_b_rvalid", avr_rvalid, 0);
        tick();
        chk("rd_rvalid", avr_rvalid, 1);
        chk("rd_rdata", avr_rdata, 8'hA5);
        chk("rd_done_oe_n", sram_oe_n, 1);
        chk("rd_done_busy", avr_busy, 0);
        tick();
        chk("rd_rvalid_clear", avr_rvalid, 0);
        chk("rd_oe_cycles", oe_cnt - o0, 2);
        chk("rd_rvalid_cycles", rv_cnt - r0, 1);

        // Write, then read back.
        w0 = we_cnt; d0 = drv_cnt;
        avr_addr   = 21'h000010;
        avr_wdata  = 8'h3C;
        avr_wr_req = 1'b1;
        tick();
        avr_wr_req = 1'b0;
        chk("wr_a_drive", sram_drive, 1);
        chk("wr_a_we_n", sram_we_n, 1);
        chk("wr_a_ce_n", sram_ce_n, 0);
        chk("wr_dout", sram_dout, 8'h3C);
        tick();
        chk("wr_b_we_n", sram_we_n, 0);
        chk("wr_b_oe_n", sram_oe_n, 1);
        tick();
        chk("wr_c_we_n", sram_we_n, 1);
        chk("wr_c_drive", sram_drive, 1);
        tick();
        chk("wr_idle_drive", sram_drive, 0);
        chk("wr_we_cycles", we_cnt - w0, 1);
        chk("wr_drive_cycles", drv_cnt - d0, 3);
        chk("wr_mem", rd_mem(21'h000010), 8'h3C);
        do_read(21'h000010, 8'h3C);

        // Simultaneous rd+wr, then a request issued while busy.
        r0 = rv_cnt; l0 = wr_log.size();
        avr_addr   = 21'h000020;
        avr_wdata  = 8'h5A;
        avr_rd_req = 1'b1;
        avr_wr_req = 1'b1;
        tick();
        chk("both_drive", sram_drive, 1);
        chk("both_oe_n", sram_oe_n, 1);
        avr_addr  = 21'h000030;
        avr_wdata = 8'h77;
        tick();
        chk("busy_addr_held", sram_addr, 21'h000020);
        chk("busy_dout_held", sram_dout, 8'h5A);
        tick();
        avr_rd_req = 1'b0;
        avr_wr_req = 1'b0;
        tick();
        tick();
        tick();
        chk("both_mem", rd_mem(21'h000020), 8'h5A);
        chk("busy_dropped", mem.exists(32'h30), 0);
        chk("both_no_rvalid", rv_cnt - r0, 0);
        chk("both_one_write", wr_log.size() - l0, 1);

        // snes_mode rises during WR_B.
        avr_addr   = 21'h000040;
        avr_wdata  = 8'hC3;
        avr_wr_req = 1'b1;
        tick();
        avr_wr_req = 1'b0;
        tick();
        chk("snes_wr_b_we_n", sram_we_n, 0);
        snes_mode = 1'b1;
        snes_addr = 21'h1FFFFF;
        snes_rd_n = 1'b0;
        force_din = 1'b1;
        din_val   = 8'h96;
        tick();
        chk("snes_wr_c_we_n", sram_we_n, 1);
        chk("snes_wr_c_drive", sram_drive, 1);
        chk("snes_wr_c_addr", sram_addr, 21'h000040);
        tick();
        chk("snes_idle_busy", avr_busy, 1);
        chk("snes_idle_ce_n", sram_ce_n, 1);
        chk("snes_wr_mem", rd_mem(21'h000040), 8'hC3);
        tick();
        chk("snes_addr", sram_addr, 21'h1FFFFF);
        chk("snes_ce_n", sram_ce_n, 0);
        chk("snes_oe_n", sram_oe_n, 0);
        chk("snes_we_n", sram_we_n, 1);
        chk("snes_drive", sram_drive, 0);
        @(negedge clk);
        #1;
        chk("snes_data_96", snes_data, 8'h96);
        din_val = 8'h3B;
        @(negedge clk);
        #1;
        chk("snes_data_3b", snes_data, 8'h3B);
        snes_rd_n = 1'b1;
        #1;
        chk("snes_oe_follow", sram_oe_n, 1);
        snes_mode = 1'b0;
        tick();
        chk("snes_exit_busy", avr_busy, 0);
        chk("snes_exit_ce_n", sram_ce_n, 1);
        chk("snes_exit_data", snes_data, 8'hFF);
        force_din = 1'b0;

        // Reset aborts a read in RD_A.
        r0 = rv_cnt;
        avr_addr   = 21'h012345;
        avr_rd_req = 1'b1;
        tick();
        avr_rd_req = 1'b0;
        chk("abort_rd_a_oe_n", sram_oe_n, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_ce_n", sram_ce_n, 1);
        chk("abort_oe_n", sram_oe_n, 1);
        chk("abort_we_n", sram_we_n, 1);
        chk("abort_busy", avr_busy, 0);
        tick();
        tick();
        tick();
        chk("abort_no_rvalid", rv_cnt - r0, 0);

`ifdef SRAM_ARB_AUTOINC_EN
        avr_addr_load = 1'b1;
        avr_addr      = 21'h1FFFFE;
        tick();
        avr_addr_load = 1'b0;
        l0 = wr_log.size();
        do_write(21'h000100, 8'h11);
        do_write(21'h000100, 8'h22);
        do_write(21'h000100, 8'h33);
        do_write(21'h000100, 8'h44);
        chk("inc_wr0", wr_log[l0], 21'h1FFFFE);
        chk("inc_wr1", wr_log[l0+1], 21'h1FFFFF);
        chk("inc_wr2", wr_log[l0+2], 21'h000000);
        chk("inc_cnt_left", wr_log[l0+3], 21'h000001);
        chk("inc_mem_wrap", rd_mem(21'h000000), 8'h33);
        chk("inc_not_avr_addr", mem.exists(32'h100), 0);
`else
        avr_addr_load = 1'b1;
        avr_addr      = 21'h000060;
        tick();
        avr_addr_load = 1'b0;
        l0 = wr_log.size();
        do_write(21'h000050, 8'hE1);
        do_write(21'h000051, 8'hE2);
        chk("noinc_wr0", wr_log[l0], 21'h000050);
        chk("noinc_wr1", wr_log[l0+1], 21'h000051);
        chk("noinc_mem", rd_mem(21'h000051), 8'hE2);
        chk("noinc_load_ignored", mem.exists(32'h60), 0);
`endif

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
